// File: rtl/im_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// IM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte to each frame.
package im_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    CSUM,
    DONE
  } state_e;

  localparam int ADDR_W_DEF     = 10;
  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/im_byte_packer.sv
// Big-endian byte-to-word packer for the loader data phase.
// IM_LOADER_CHECKSUM_EN keeps a running XOR of every pushed byte.
module im_byte_packer
  import im_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  output logic        word_full_o,
  output logic [31:0] word_o,
  output logic [7:0]  csum_o
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  // The count wraps after the 4th byte, which empties the packer as the word is written.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (push_i) begin
      shift_q <= {shift_q[15:0], byte_i};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

  assign word_full_o = push_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word_o      = {shift_q, byte_i};

`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      csum_q <= '0;
    end else if (push_i) begin
      csum_q <= csum_q ^ byte_i;
    end
  end

  assign csum_o = csum_q;
`else
  assign csum_o = '0;
`endif

endmodule

// File: rtl/im_loader.sv
// Streams a length-prefixed byte frame into instruction RAM, holding the CPU meanwhile.
// IM_LOADER_CHECKSUM_EN adds the CSUM state and drives err from the checksum compare.
module im_loader
  import im_pkg::*;
#(
  parameter int              ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              cpu_hold,
  output logic              done,
  output logic              overflow,
  output logic              err
);

`ifdef IM_LOADER_CHECKSUM_EN
  localparam state_e END_ST  = CSUM;
  localparam bit     CSUM_EN = 1'b1;
`else
  localparam state_e END_ST  = DONE;
  localparam bit     CSUM_EN = 1'b0;
`endif

  state_e            state_q;
  logic [15:0]       len_q;
  logic [15:0]       idx_q;
  logic              byte_ready_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [31:0]       ram_din_q;
  logic              cpu_hold_q;
  logic              done_q;
  logic              overflow_q;
  logic              err_q;

  logic              xfer;
  logic              begin_load;
  logic              word_full;
  logic [31:0]       next_word;
  logic [7:0]        csum;
  logic              in_cap;
  logic [ADDR_W-1:0] addr_calc;
  logic [15:0]       idx_inc;

  assign xfer       = byte_valid && byte_ready_q;
  assign begin_load = start && ((state_q == IDLE) || (state_q == DONE));
  assign in_cap     = (32'(idx_q) >> ADDR_W) == 32'd0;
  assign addr_calc  = BASE_ADDR + ADDR_W'(idx_q);
  assign idx_inc    = idx_q + 16'd1;

  im_byte_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (begin_load),
    .push_i      (xfer && (state_q == DATA)),
    .byte_i      (byte_data),
    .word_full_o (word_full),
    .word_o      (next_word),
    .csum_o      (csum)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      byte_ready_q <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= BASE_ADDR;
      ram_din_q    <= '0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      ram_we_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q      <= LEN_HI;
            idx_q        <= '0;
            byte_ready_q <= 1'b1;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            err_q        <= 1'b0;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            len_q[15:8] <= byte_data;
            state_q     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            len_q[7:0] <= byte_data;
            if ({len_q[15:8], byte_data} == 16'd0) begin
              state_q      <= END_ST;
              byte_ready_q <= (END_ST == CSUM);
              cpu_hold_q   <= (END_ST == CSUM);
              done_q       <= (END_ST == DONE);
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (word_full) begin
            state_q      <= WRITE;
            byte_ready_q <= 1'b0;
            ram_din_q    <= next_word;
            // Out-of-range words are swallowed so the host stream stays in sync.
            if (in_cap) begin
              ram_we_q   <= 1'b1;
              ram_addr_q <= addr_calc;
            end else begin
              overflow_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          idx_q <= idx_inc;
          if (idx_inc == len_q) begin
            state_q      <= END_ST;
            byte_ready_q <= (END_ST == CSUM);
            cpu_hold_q   <= (END_ST == CSUM);
            done_q       <= (END_ST == DONE);
          end else begin
            state_q      <= DATA;
            byte_ready_q <= 1'b1;
          end
        end
        CSUM: begin
          if (xfer) begin
            if (byte_data != csum) err_q <= 1'b1;
            state_q      <= DONE;
            byte_ready_q <= 1'b0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_ready = byte_ready_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_din    = ram_din_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign err        = CSUM_EN && err_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: a default instance plus an ADDR_W=2 instance on shared stimulus.
// Define IM_LOADER_CHECKSUM_EN for both RTL and bench to exercise the checksum byte.
module tb_im_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;

  logic        byte_ready, ram_we, cpu_hold, done, overflow, err;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;

  logic        byte_ready2, ram_we2, cpu_hold2, done2, overflow2, err2;
  logic [1:0]  ram_addr2;
  logic [31:0] ram_din2;

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_viol = 0;

  logic [9:0]  log_addr[$];
  logic [31:0] log_din[$];
  logic [1:0]  log2_addr[$];
  logic [31:0] frame_w[8];

  im_loader #(.ADDR_W(10), .BASE_ADDR(10'd0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .cpu_hold(cpu_hold), .done(done), .overflow(overflow), .err(err)
  );

  im_loader #(.ADDR_W(2), .BASE_ADDR(2'd0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready2), .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_din(ram_din2),
    .cpu_hold(cpu_hold2), .done(done2), .overflow(overflow2), .err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      log_addr.push_back(ram_addr);
      log_din.push_back(ram_din);
      if (byte_ready !== 1'b0) rdy_viol++;
    end
    if (ram_we2 === 1'b1) log2_addr.push_back(ram_addr2);
  end

  task automatic clear_logs();
    log_addr.delete();
    log_din.delete();
    log2_addr.delete();
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int i = 0; i < gap; i++) begin
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      tick(1);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (byte_ready !== 1'b1 && t < 50) begin
      tick(1);
      t++;
    end
    if (t >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_byte_timeout: byte_ready=%b required 1", byte_ready);
    end
    tick(1);
    byte_valid = 1'b0;
  endtask

  // Sends N words from frame_w; max_gap>0 inserts random idle cycles before bytes.
  task automatic send_frame(input int n, input int max_gap, input logic [7:0] csum_flip);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    send_byte(8'(n >> 8), 0);
    send_byte(8'(n), 0);
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'(frame_w[w] >> (24 - 8 * k));
        x = x ^ b;
        send_byte(b, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
      end
      n_checks++;
      if (ram_we !== 1'b1 || ram_din !== frame_w[w]) begin
        n_fail++;
        $display("FAIL write_latency word %0d: ram_we=%b din=%h required 1 %h", w, ram_we, ram_din, frame_w[w]);
      end
    end
`ifdef IM_LOADER_CHECKSUM_EN
    send_byte(x ^ csum_flip, 0);
`else
    if (csum_flip != 8'h00) x = x ^ csum_flip;
`endif
    tick(3);
  endtask

  task automatic check_two_word_result(input string name);
    n_checks++;
    if (log_addr.size() != 2) begin
      n_fail++;
      $display("FAIL %s_count: writes=%0d required 2", name, log_addr.size());
    end else begin
      n_checks++;
      if (log_addr[0] !== 10'd0 || log_din[0] !== 32'h24010005 ||
          log_addr[1] !== 10'd1 || log_din[1] !== 32'h0000000C) begin
        n_fail++;
        $display("FAIL %s_data: %h@%0d %h@%0d required 24010005@0 0000000c@1",
                 name, log_din[0], log_addr[0], log_din[1], log_addr[1]);
      end
    end
    n_checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_status: done=%b hold=%b ovf=%b required 1 0 0", name, done, cpu_hold, overflow);
    end
    n_checks++;
    if (rdy_viol != 0) begin
      n_fail++;
      $display("FAIL %s_ready_in_write: violations=%0d required 0", name, rdy_viol);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    tick(3);
    n_checks++;
    if (byte_ready !== 1'b0 || ram_we !== 1'b0 || cpu_hold !== 1'b0 || done !== 1'b0 ||
        overflow !== 1'b0 || err !== 1'b0 || ram_addr !== 10'd0 || ram_din !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b we=%b hold=%b done=%b ovf=%b err=%b addr=%h din=%h required all 0",
               byte_ready, ram_we, cpu_hold, done, overflow, err, ram_addr, ram_din);
    end
    rst_n = 1'b1;
    start = 1'b0;
    tick(2);
    n_checks++;
    if (cpu_hold !== 1'b0 || byte_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_outputs: hold=%b rdy=%b required 0 0", cpu_hold, byte_ready);
    end
    pulse_start();
    n_checks++;
    if (cpu_hold !== 1'b1 || byte_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL start_response: hold=%b rdy=%b done=%b required 1 1 0", cpu_hold, byte_ready, done);
    end
  endtask

  task automatic test_basic_frame();
    clear_logs();
    rdy_viol = 0;
    frame_w[0] = 32'h24010005;
    frame_w[1] = 32'h0000000C;
    send_frame(2, 0, 8'h00);
    check_two_word_result("basic");
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_err: err=%b required 0", err);
    end
  endtask

  task automatic test_back_to_back_toggle();
    clear_logs();
    rdy_viol = 0;
    pulse_start();
    n_checks++;
    if (done !== 1'b0 || cpu_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_clears_done: done=%b hold=%b required 0 1", done, cpu_hold);
    end
    send_frame(2, 3, 8'h00);
    check_two_word_result("toggle");
  endtask

  task automatic test_overflow();
    clear_logs();
    pulse_start();
    for (int i = 0; i < 5; i++) frame_w[i] = 32'hA0B0C000 + 32'(i);
    send_frame(5, 0, 8'h00);
    n_checks++;
    if (log2_addr.size() != 4) begin
      n_fail++;
      $display("FAIL ovf_write_count: writes=%0d required 4", log2_addr.size());
    end else begin
      n_checks++;
      if (log2_addr[0] !== 2'd0 || log2_addr[1] !== 2'd1 || log2_addr[2] !== 2'd2 || log2_addr[3] !== 2'd3) begin
        n_fail++;
        $display("FAIL ovf_addrs: %0d %0d %0d %0d required 0 1 2 3",
                 log2_addr[0], log2_addr[1], log2_addr[2], log2_addr[3]);
      end
    end
    n_checks++;
    if (overflow2 !== 1'b1 || done2 !== 1'b1 || cpu_hold2 !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_status: ovf=%b done=%b hold=%b required 1 1 0", overflow2, done2, cpu_hold2);
    end
    n_checks++;
    if (overflow !== 1'b0 || log_addr.size() != 5) begin
      n_fail++;
      $display("FAIL wide_no_ovf: ovf=%b writes=%0d required 0 5", overflow, log_addr.size());
    end
  endtask

  task automatic test_start_ignored();
    clear_logs();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    pulse_start();
    send_byte(8'h34, 0);
    send_byte(8'h56, 0);
    send_byte(8'h78, 0);
    tick(3);
    n_checks++;
    if (log_din.size() != 1 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL start_ignored: writes=%0d done=%b required 1 1", log_din.size(), done);
    end else begin
      n_checks++;
      if (log_din[0] !== 32'h12345678 || log_addr[0] !== 10'd0) begin
        n_fail++;
        $display("FAIL start_ignored_word: %h@%0d required 12345678@0", log_din[0], log_addr[0]);
      end
    end
`ifdef IM_LOADER_CHECKSUM_EN
    send_byte(8'h08, 0);
    tick(2);
`endif
  endtask

  task automatic test_zero_len();
    clear_logs();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef IM_LOADER_CHECKSUM_EN
    n_checks++;
    if (done !== 1'b0 || byte_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_len_csum_wait: done=%b rdy=%b required 0 1", done, byte_ready);
    end
    send_byte(8'h00, 0);
`endif
    n_checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || log_addr.size() != 0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len: done=%b hold=%b writes=%0d err=%b required 1 0 0 0",
               done, cpu_hold, log_addr.size(), err);
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst_n = 1'b0;
    tick(1);
    n_checks++;
    if (byte_ready !== 1'b0 || ram_we !== 1'b0 || cpu_hold !== 1'b0 || done !== 1'b0 ||
        overflow !== 1'b0 || err !== 1'b0 || ram_addr !== 10'd0 || ram_din !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: rdy=%b we=%b hold=%b done=%b addr=%h din=%h required all 0",
               byte_ready, ram_we, cpu_hold, done, ram_addr, ram_din);
    end
    rst_n = 1'b1;
    tick(1);
    n_checks++;
    if (log_addr.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_writes: writes=%0d required 0", log_addr.size());
    end
    pulse_start();
    frame_w[0] = 32'hDEADBEEF;
    send_frame(1, 0, 8'h00);
    n_checks++;
    if (log_din.size() != 1 || log_din[0] !== 32'hDEADBEEF || log_addr[0] !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_mid_reload: writes=%0d first=%h required 1 deadbeef", log_din.size(),
               (log_din.size() > 0) ? log_din[0] : 32'h0);
    end
  endtask

`ifdef IM_LOADER_CHECKSUM_EN
  task automatic test_bad_checksum();
    clear_logs();
    rdy_viol = 0;
    pulse_start();
    frame_w[0] = 32'h24010005;
    frame_w[1] = 32'h0000000C;
    send_frame(2, 0, 8'h01);
    check_two_word_result("badcsum");
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_checksum_err: err=%b required 1", err);
    end
    pulse_start();
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear_on_start: err=%b required 0", err);
    end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    tick(1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back_toggle();
    test_overflow();
    test_start_ignored();
    test_zero_len();
    test_reset_mid();
`ifdef IM_LOADER_CHECKSUM_EN
    test_bad_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
